// File: rtl/mips_mdu.sv
// mips_mdu: iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use radix-2 shift-add. DIV/DIVU use restoring radix-2 division.
// Both operate on operand magnitudes, and a FIX cycle applies sign correction.
// Latency is fixed: start at edge E0 -> busy for WIDTH+1 cycles -> done pulse.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, op, a, b    launch request, opcode (00 MULT 01 MULTU 10 DIV 11 DIVU), operands
//   flush              squash the in-flight operation
//   wr_hi, wr_lo,      MTHI/MTLO strobes and data
//   wr_data
//   busy, done         operation in flight / one-cycle result-ready pulse
//   div_by_zero        last divide had a zero divisor (held until next done)
//   hi, lo             HI/LO registers
module mips_mdu #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Mult: {partial product upper, remaining multiplier bits}.
  // Div:  {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Multiplicand magnitude (mult) or divisor magnitude (div).
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  assign accept = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign sgn   = SIGNED_EN && !op[0];
  assign a_neg = sgn && a[WIDTH-1];
  assign b_neg = sgn && b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // One shift-add step: add the multiplicand when the current multiplier LSB is
  // set, then shift the whole register right, keeping the carry.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // One restoring step: shift the next dividend bit into the remainder. A borrow
  // out of the W+1-bit difference means the trial subtraction is discarded.
  assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = rem_diff[WIDTH]
                  ? {rem_sh[WIDTH-1:0],   prod_q[WIDTH-2:0], 1'b0}
                  : {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  assign prod_neg = ~prod_q + 1'b1;
  assign quo      = neg_q  ? (~prod_q[WIDTH-1:0] + 1'b1)       : prod_q[WIDTH-1:0];
  assign rem      = rneg_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          bz_d     = (b == '0);
          a_d      = a;
          opnd_d   = op[1] ? b_mag : a_mag;
          prod_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end else begin
          state_d = S_IDLE;
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d = is_div_q ? div_next : mul_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      default: begin // S_FIX
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          dbz_d   = is_div_q && bz_q;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
          end else if (bz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed bench for mips_mdu (WIDTH=32, SIGNED_EN=1).
// Expected results come from a reference model built on native 64-bit
// arithmetic. They are queued when an operation launches and popped on done.
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        reset, start, flush, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mips_mdu #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int sx, sy;
    longint p;
    longint unsigned pu;
    sx = x;
    sy = y;
    r.dbz = 1'b0;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        pu = {32'b0, x} * {32'b0, y};
        r.hi = pu[63:32];
        r.lo = pu[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == 2'b11) begin
          r.lo = x / y; r.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          r.lo = sx / sy; r.hi = sx % sy;
        end
      end
    endcase
    return r;
  endfunction

  // Drives start for one edge; returns in the first cycle after acceptance.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push = 1'b1);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    if (push) sb.push_back(model(o, x, y));
  endtask

  // cyc0: cycle index (relative to the accept edge) at which this is called.
  task automatic wait_done(input string tag, input int unsigned cyc0);
    int unsigned cyc = cyc0;
    int unsigned bcnt = cyc0 - 1;
    exp_t e;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd34);
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, " scoreboard_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " hi"}, 64'(hi), 64'(e.hi));
      chk({tag, " lo"}, 64'(lo), 64'(e.lo));
      chk({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
    end
  endtask

  initial begin
    int unsigned dcount;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wr_data = '0;
    tick(); tick();
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    tick();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 1);
    chk("multu_max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max lo const", 64'(lo), 64'd1);
    tick();
    chk("done one cycle", 64'(done), 64'd0);

    issue(2'b00, 32'hFFFF_FFF9, 32'd6);
    wait_done("mult_neg", 1);
    chk("mult_neg lo const", 64'(lo), 64'h0000_0000_FFFF_FFD6);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);  // back-to-back from the done cycle
    wait_done("div_neg", 1);
    chk("div_neg hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("div_neg lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);

    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_with_flush busy", 64'(busy), 64'd0);
    chk("start_with_flush hi kept", 64'(hi), 64'h0000_0000_FFFF_FFFF);

    issue(2'b11, 32'd100, 32'd7);
    wait_done("divu_100_7", 1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1);
    issue(2'b11, 32'd5, 32'd0);
    wait_done("divu_zero", 1);
    chk("divu_zero dbz const", 64'(div_by_zero), 64'd1);
    tick(); tick(); tick();
    chk("dbz held", 64'(div_by_zero), 64'd1);
    issue(2'b01, 32'd3, 32'd4);
    wait_done("multu_3_4", 1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 0) ry = -32'd13;
      issue(ro, rx, ry);
      wait_done($sformatf("rand%0d op%0d", i, ro), 1);
    end

    issue(2'b01, 32'd11, 32'd13);
    tick(); tick(); tick();
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    wait_done("start_ignored", 5);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("no queued start", 64'(dcount), 64'd0);

    issue(2'b01, 32'd123, 32'd456, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    chk("flush no done", 64'(dcount), 64'd0);
    chk("flush hi kept", 64'(hi), 64'd0);
    chk("flush lo kept", 64'(lo), 64'd143);

    wr_hi = 1'b1; wr_data = 32'h1234;
    tick();
    wr_hi = 1'b0;
    chk("mthi idle", 64'(hi), 64'h1234);
    chk("mthi lo untouched", 64'(lo), 64'd143);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthi+mtlo hi", 64'(hi), 64'hCAFE);
    chk("mthi+mtlo lo", 64'(lo), 64'hCAFE);

    issue(2'b01, 32'd2, 32'd3);
    tick();
    wr_hi = 1'b1; wr_data = 32'hDEAD;
    tick();
    wr_hi = 1'b0;
    chk("mthi busy ignored", 64'(hi), 64'hCAFE);
    wait_done("multu_2_3", 3);
    wr_lo = 1'b1; wr_data = 32'hABCD;
    tick();
    wr_lo = 1'b0;
    chk("mtlo in done lo", 64'(lo), 64'hABCD);
    chk("mtlo in done hi", 64'(hi), 64'd0);

    wr_hi = 1'b1; wr_data = 32'h5555;
    issue(2'b11, 32'd9, 32'd0);
    wr_hi = 1'b0;
    chk("mthi with start ignored", 64'(hi), 64'd0);
    wait_done("divu_9_0", 1);

    issue(2'b10, -32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset hi", 64'(hi), 64'd0);
    chk("mid reset lo", 64'(lo), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    chk("mid reset dbz", 64'(div_by_zero), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. Launches MULT/MULTU/DIV/DIVU from operand values after forwarding.
- Holds the pipeline via busy/done for a fixed, known latency.
- Also serves MTHI/MTLO writes; hi/lo outputs feed the MFHI/MFLO path.

Parameters:
- WIDTH, 32: operand width. Also the width of HI and LO. Must be even and >= 4.
- SIGNED_EN, 1: 1 enables the signed ops. When 0, ops 00 and 10 behave as 01 and 11 (unsigned).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request, sampled at the rising edge.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand; multiplicand or dividend.
- b  input  WIDTH  rt operand; multiplier or divisor.
- flush  input  1  abort the in-flight operation (branch/exception squash).
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wr_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; the pipeline stalls any MFHI/MFLO/MDU op.
- done  output  1  one-cycle pulse: hi/lo hold the new result.
- div_by_zero  output  1  valid with done: the last divide had b == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal counter and accumulators cleared.
- Reset has priority over every other input, including mid-operation.
- States:
  - IDLE: accepts start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and result write.
  - DONE: output pulse.
- Latency, with start sampled at edge E0:
  - busy=1 for the WIDTH+1 cycles after E0 (RUN x WIDTH, then FIX).
  - hi/lo update and done=1 in the cycle after FIX, i.e. WIDTH+2 cycles after E0.
  - busy=0 in the DONE cycle.
  - done lasts exactly one cycle.
- start is accepted in IDLE or DONE (back-to-back allowed). a, b and op are captured at acceptance and need not be held.
- start while busy=1 is ignored; no queueing.
- Multiply:
  - Radix-2 shift-add on operand magnitudes (absolute values when signed and SIGNED_EN=1).
  - FIX negates the 2*WIDTH-bit product if the operand signs differ.
  - hi = product[2W-1:W], lo = product[W-1:0].
- Divide:
  - Restoring radix-2 on magnitudes; lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0, div_by_zero=0.
  - b == 0: full latency still taken; lo = all ones, hi = a, div_by_zero=1 with done.
- div_by_zero holds its value until the next done pulse.
- flush:
  - In RUN or FIX: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
  - flush together with start in IDLE or DONE: start is ignored.
- wr_hi / wr_lo:
  - Take effect at the edge if busy=0 and no start is accepted that cycle.
  - Ignored while busy, and ignored in the cycle a start is accepted.
  - Both strobes together write both registers.
  - A write in the DONE cycle overwrites the freshly written result.
- hi/lo change only on reset, result write, or an accepted MTHI/MTLO write.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; next start issued in the done cycle is accepted.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Start MULTU, assert flush 10 cycles later -> busy=0 next cycle, no done, hi/lo keep prior values. A start pulsed mid-run -> ignored.
- wr_hi=1, wr_data=0x1234 while idle -> hi=0x1234 next cycle. Same write while busy -> ignored. reset asserted mid-divide -> all outputs 0 next cycle.
